// File: rtl/usb_rx_pkg.sv
// ----------------------------------------------------------------------------
// usb_rx_pkg: shared types and constants for the full-speed USB RX front end
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    EOP   = 3'd3,
    ERROR = 3'd4
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

endpackage

`default_nettype wire

// File: rtl/usb_rx_packetizer_bit_decoder.sv
// ----------------------------------------------------------------------------
// rx_bit_decoder: line synchronizers, bit timer, NRZI decode and bit unstuffing
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rx_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus,
  input  logic d_minus,
  input  logic start,
  input  logic active,
  output logic dp_fall,
  output logic bit_valid,
  output logic bit_val,
  output logic se0,
  output logic stuff_err,
  output logic idle_j
);

  localparam int             TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]  TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  SAMPLE_AT = TW'(SAMPLE_PHASE);

  logic          dp_meta_q, dp_q, dm_meta_q, dm_q, dp_prev_q;
  logic          last_dp_q, last_dp_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    ones_q, ones_d;

  logic sample, line_se0, nrzi_bit, stuff_slot;

  // Synchronizers reset to J so an idle bus never looks like a start edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta_q <= 1'b1;
      dp_q      <= 1'b1;
      dm_meta_q <= 1'b0;
      dm_q      <= 1'b0;
      dp_prev_q <= 1'b1;
      last_dp_q <= 1'b1;
      timer_q   <= '0;
      ones_q    <= '0;
    end else begin
      dp_meta_q <= d_plus;
      dp_q      <= dp_meta_q;
      dm_meta_q <= d_minus;
      dm_q      <= dm_meta_q;
      dp_prev_q <= dp_q;
      last_dp_q <= last_dp_d;
      timer_q   <= timer_d;
      ones_q    <= ones_d;
    end
  end

  assign sample     = active && (timer_q == SAMPLE_AT);
  assign line_se0   = !dp_q && !dm_q;
  assign nrzi_bit   = (dp_q == last_dp_q);
  assign stuff_slot = (ones_q == STUFF_LIMIT);

  always_comb begin
    timer_d   = timer_q;
    last_dp_d = last_dp_q;
    ones_d    = ones_q;
    if (start) begin
      timer_d   = '0;
      last_dp_d = 1'b1;
      ones_d    = '0;
    end else begin
      if (active) begin
        timer_d = (timer_q == TIMER_MAX) ? '0 : timer_q + 1'b1;
      end
      if (sample && !line_se0) begin
        last_dp_d = dp_q;
        if (stuff_slot) begin
          ones_d = '0;
        end else begin
          ones_d = nrzi_bit ? ones_q + 3'd1 : 3'd0;
        end
      end
    end
  end

  assign dp_fall   = dp_prev_q && !dp_q;
  assign bit_val   = nrzi_bit;
  assign bit_valid = sample && !line_se0 && !stuff_slot;
  assign stuff_err = sample && !line_se0 && stuff_slot && nrzi_bit;
  assign se0       = sample && line_se0;
  assign idle_j    = sample && !line_se0 && dp_q;

endmodule

`default_nettype wire

// File: rtl/usb_rx_packetizer.sv
// ----------------------------------------------------------------------------
// usb_rx_packetizer: full-speed USB receive packetizer feeding rx_fifo
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module usb_rx_packetizer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       full,
  output logic       w_enable,
  output logic [7:0] w_data,
  output logic       rcving,
  output logic       r_error
);

  rx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       w_enable_q, w_enable_d;
  logic [7:0] w_data_q, w_data_d;
  logic       rcving_q, rcving_d;
  logic       r_error_q, r_error_d;

  logic       start, active, to_error;
  logic       dp_fall, bit_valid, bit_val, se0, stuff_err, idle_j;
  logic [7:0] new_byte;

  assign active = (state_q != IDLE);
  assign start  = (state_q == IDLE) && dp_fall;

  rx_bit_decoder #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_PHASE (SAMPLE_PHASE)
  ) u_bit_decoder (
    .clk       (clk),
    .n_rst     (n_rst),
    .d_plus    (d_plus),
    .d_minus   (d_minus),
    .start     (start),
    .active    (active),
    .dp_fall   (dp_fall),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .se0       (se0),
    .stuff_err (stuff_err),
    .idle_j    (idle_j)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      w_enable_q <= 1'b0;
      w_data_q   <= '0;
      rcving_q   <= 1'b0;
      r_error_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      w_enable_q <= w_enable_d;
      w_data_q   <= w_data_d;
      rcving_q   <= rcving_d;
      r_error_q  <= r_error_d;
    end
  end

  // Bits arrive LSB-first, so each kept bit enters at the MSB
  assign new_byte = {bit_val, shift_q[7:1]};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    w_enable_d = 1'b0;
    w_data_d   = w_data_q;
    rcving_d   = rcving_q;
    r_error_d  = r_error_q;
    to_error   = 1'b0;

    case (state_q)
      IDLE: begin
        if (dp_fall) begin
          state_d   = SYNC;
          shift_d   = '0;
          bit_cnt_d = '0;
          rcving_d  = 1'b1;
          r_error_d = 1'b0;
        end
      end
      SYNC: begin
        if (se0) begin
          to_error = 1'b1;
        end else if (bit_valid) begin
          shift_d   = new_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (new_byte == SYNC_BYTE) begin
              state_d = DATA;
            end else begin
              to_error = 1'b1;
            end
          end
        end
      end
      DATA: begin
        if (se0) begin
          if (bit_cnt_q == 3'd0) begin
            state_d = EOP;
          end else begin
            to_error = 1'b1;
          end
        end else if (stuff_err) begin
          to_error = 1'b1;
        end else if (bit_valid) begin
          shift_d   = new_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // A byte landing on a full FIFO is dropped but the packet carries on
            if (full) begin
              r_error_d = 1'b1;
            end else begin
              w_enable_d = 1'b1;
              w_data_d   = new_byte;
            end
          end
        end
      end
      EOP: begin
        if (idle_j) begin
          state_d  = IDLE;
          rcving_d = 1'b0;
        end
      end
      ERROR: begin
        r_error_d = 1'b1;
        if (se0) begin
          state_d = EOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (to_error) begin
      state_d   = ERROR;
      r_error_d = 1'b1;
    end
  end

  assign w_enable = w_enable_q;
  assign w_data   = w_data_q;
  assign rcving   = rcving_q;
  assign r_error  = r_error_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_rx_packetizer.sv
// ----------------------------------------------------------------------------
// tb_usb_rx_packetizer: directed, table-driven bench for usb_rx_packetizer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_usb_rx_packetizer;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_plus;
  logic       d_minus;
  logic       full;
  logic       w_enable;
  logic [7:0] w_data;
  logic       rcving;
  logic       r_error;

  int n_checks = 0;
  int n_errors = 0;

  logic       lvl;
  int         ones;
  logic [7:0] wr_q[$];

  typedef struct {
    logic [7:0]  sync;
    logic [23:0] data;
    int          nbytes;
    int          extra;
    logic        full_v;
    int          exp_n;
    logic [23:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  usb_rx_packetizer #(
    .CLKS_PER_BIT (CPB),
    .SAMPLE_PHASE (3)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .d_plus   (d_plus),
    .d_minus  (d_minus),
    .full     (full),
    .w_enable (w_enable),
    .w_data   (w_data),
    .rcving   (rcving),
    .r_error  (r_error)
  );

  always #5 clk = ~clk;

  // Every cycle with the strobe high is one FIFO write
  always @(negedge clk) begin
    if (w_enable === 1'b1) wr_q.push_back(w_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic p, input logic m);
    d_plus  = p;
    d_minus = m;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // NRZI encoder with stuffing: a 0 toggles the line, six 1s force a 0
  task automatic tx_bit(input logic b);
    if (!b) begin
      lvl  = ~lvl;
      ones = 0;
    end else begin
      ones++;
    end
    drive_bit(lvl, ~lvl);
    if (ones == 6) begin
      lvl  = ~lvl;
      ones = 0;
      drive_bit(lvl, ~lvl);
    end
  endtask

  task automatic tx_byte(input logic [7:0] v, input int nb);
    for (int k = 0; k < nb; k++) tx_bit(v[k]);
  endtask

  task automatic tx_eop();
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    lvl = 1'b1;
    repeat (3) drive_bit(1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_enable"}, {31'd0, w_enable}, 32'd0);
    check({tag, "_w_data"},   {24'd0, w_data},   32'd0);
    check({tag, "_rcving"},   {31'd0, rcving},   32'd0);
    check({tag, "_r_error"},  {31'd0, r_error},  32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h80, 24'h0000A5, 1, 0, 1'b0, 1, 24'h0000A5, 1'b0};
    vecs[1] = '{8'h80, 24'h0001FF, 2, 0, 1'b0, 2, 24'h0001FF, 1'b0};
    vecs[2] = '{8'h00, 24'h000000, 0, 0, 1'b0, 0, 24'h000000, 1'b1};
    vecs[3] = '{8'h80, 24'h00007E, 1, 0, 1'b0, 1, 24'h00007E, 1'b0};
    vecs[4] = '{8'h80, 24'h00003C, 1, 0, 1'b1, 0, 24'h000000, 1'b1};
    vecs[5] = '{8'h80, 24'h00003C, 1, 0, 1'b0, 1, 24'h00003C, 1'b0};
    vecs[6] = '{8'h80, 24'h000005, 0, 3, 1'b0, 0, 24'h000000, 1'b1};

    n_rst   = 1'b0;
    d_plus  = 1'b1;
    d_minus = 1'b0;
    full    = 1'b0;
    lvl     = 1'b1;
    ones    = 0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (3) drive_bit(1'b1, 1'b0);

    for (int i = 0; i < 7; i++) begin
      wr_q.delete();
      full = vecs[i].full_v;
      lvl  = 1'b1;
      ones = 0;
      tx_byte(vecs[i].sync, 8);
      check($sformatf("v%0d_rcving_mid", i), {31'd0, rcving}, 32'd1);
      for (int j = 0; j < vecs[i].nbytes; j++) tx_byte(vecs[i].data[8*j +: 8], 8);
      if (vecs[i].extra > 0) tx_byte(vecs[i].data[8*vecs[i].nbytes +: 8], vecs[i].extra);
      tx_eop();
      full = 1'b0;
      check($sformatf("v%0d_writes", i), wr_q.size(), vecs[i].exp_n);
      for (int j = 0; j < vecs[i].exp_n; j++) begin
        check($sformatf("v%0d_data%0d", i, j),
              (j < wr_q.size()) ? {24'd0, wr_q[j]} : 32'hFFFF_FFFF,
              {24'd0, vecs[i].exp_data[8*j +: 8]});
      end
      check($sformatf("v%0d_r_error", i), {31'd0, r_error}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_rcving_end", i), {31'd0, rcving}, 32'd0);
    end

    // Interrupted packet: dropped byte sets r_error, then reset lands mid-byte
    wr_q.delete();
    full = 1'b1;
    lvl  = 1'b1;
    ones = 0;
    tx_byte(8'h80, 8);
    tx_byte(8'h11, 8);
    tx_byte(8'h5A, 3);
    check("mid_r_error", {31'd0, r_error}, 32'd1);
    check("mid_rcving",  {31'd0, rcving},  32'd1);
    @(negedge clk);
    n_rst   = 1'b0;
    d_plus  = 1'b1;
    d_minus = 1'b0;
    full    = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (3) drive_bit(1'b1, 1'b0);

    wr_q.delete();
    lvl  = 1'b1;
    ones = 0;
    tx_byte(8'h80, 8);
    tx_byte(8'h5A, 8);
    tx_eop();
    check("post_reset_writes", wr_q.size(), 1);
    check("post_reset_data", (wr_q.size() > 0) ? {24'd0, wr_q[0]} : 32'hFFFF_FFFF, 32'h5A);
    check("post_reset_r_error", {31'd0, r_error}, 32'd0);
    check("post_reset_rcving",  {31'd0, rcving},  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
